dcache_tag_flush: RTL and testbench



---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_tag_flush.sv | 171 +++++++++++++++++
 tb/tb_dcache_tag_flush.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data-cache tag path.
//   - Tag word layout: [20] valid, [19] dirty, [18:0] tag address bits [31:13].
//   - Cache geometry: line count and byte-offset width.
//   - Flush/invalidate walker state encoding.
package dcache_pkg;

  localparam int unsigned TAG_VALID_BIT        = 20;
  localparam int unsigned TAG_DIRTY_BIT        = 19;
  localparam int unsigned TAG_ADDR_W           = 19;
  localparam int unsigned TAG_WORD_W           = TAG_ADDR_W + 2;
  localparam int unsigned DCACHE_LINES         = 256;
  localparam int unsigned DCACHE_LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_WB    = 2'd3
  } walk_state_t;

  // Assemble a tag RAM word from its fields.
  function automatic logic [TAG_WORD_W-1:0] tag_word(input logic                  valid,
                                                      input logic                  dirty,
                                                      input logic [TAG_ADDR_W-1:0] tag);
    tag_word = {valid, dirty, tag};
  endfunction

endpackage

// File: rtl/dcache_tag_flush.sv
// dcache_tag_flush: write-side controller for the data-cache tag RAM.
//   Applies single-line refill tag updates and runs full-cache flush
//   (write back dirty lines, then invalidate) or invalidate-only walks.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush_i / invalidate_i     walk start pulses (flush wins if both)
//   busy_o / done_o            walk in progress / one-cycle completion pulse
//   upd_valid_i/upd_ready_o    refill tag update handshake
//   upd_index_i/tag_i/dirty_i  refill update payload
//   tag_rd_addr_o/rd_data_i    tag RAM read port (data one cycle after addr)
//   tag_wr_o/addr_o/data_o     tag RAM write port
//   wb_req_o/addr_o/ack_i      memory write-back request handshake
//   wb_count_o                 write-backs acked in the last walk
//                              (only when DCACHE_FLUSH_STATS_EN is defined)
module dcache_tag_flush
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES     = DCACHE_LINES,
  parameter int unsigned LINE_OFFSET_W = DCACHE_LINE_OFFSET_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        invalidate_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        upd_valid_i,
  output logic        upd_ready_o,
  input  logic [7:0]  upd_index_i,
  input  logic [18:0] upd_tag_i,
  input  logic        upd_dirty_i,
  output logic [7:0]  tag_rd_addr_o,
  input  logic [20:0] tag_rd_data_i,
  output logic        tag_wr_o,
  output logic [7:0]  tag_wr_addr_o,
  output logic [20:0] tag_wr_data_o,
  output logic        wb_req_o,
  output logic [31:0] wb_addr_o,
  input  logic        wb_ack_i
`ifdef DCACHE_FLUSH_STATS_EN
  ,
  output logic [8:0]  wb_count_o
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_LINES - 1);

  walk_state_t r_state;
  walk_state_t w_next;
  logic [7:0]  r_index;
  logic [7:0]  w_index_nxt;
  logic        r_flush_mode;
  logic        r_done;
  logic        r_wb_req;
  logic [31:0] r_wb_addr;

  logic        w_start;
  logic        w_wb_load;
  logic        w_line_done;
  logic        w_walk_end;
  logic        w_line_dirty;

  assign w_line_dirty = tag_rd_data_i[TAG_VALID_BIT] & tag_rd_data_i[TAG_DIRTY_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_index      <= '0;
      r_flush_mode <= 1'b0;
      r_done       <= 1'b0;
      r_wb_req     <= 1'b0;
      r_wb_addr    <= '0;
    end else begin
      r_state <= w_next;
      r_index <= w_index_nxt;
      r_done  <= w_walk_end;
      if (w_start) begin
        r_flush_mode <= flush_i;
      end
      if (w_wb_load) begin
        r_wb_req  <= 1'b1;
        r_wb_addr <= {tag_rd_data_i[TAG_ADDR_W-1:0], r_index, {LINE_OFFSET_W{1'b0}}};
      end else if (r_state == ST_WB && wb_ack_i) begin
        r_wb_req <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_index_nxt   = r_index;
    w_start       = 1'b0;
    w_wb_load     = 1'b0;
    w_line_done   = 1'b0;
    w_walk_end    = 1'b0;
    upd_ready_o   = 1'b0;
    tag_rd_addr_o = '0;
    tag_wr_o      = 1'b0;
    tag_wr_addr_o = '0;
    tag_wr_data_o = '0;

    unique case (r_state)
      ST_IDLE: begin
        upd_ready_o = ~flush_i & ~invalidate_i;
        if (upd_valid_i && upd_ready_o) begin
          tag_wr_o      = 1'b1;
          tag_wr_addr_o = upd_index_i;
          tag_wr_data_o = tag_word(1'b1, upd_dirty_i, upd_tag_i);
        end
        if (flush_i || invalidate_i) begin
          w_start     = 1'b1;
          w_index_nxt = '0;
          w_next      = ST_READ;
        end
      end
      ST_READ: begin
        tag_rd_addr_o = r_index;
        w_next        = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_flush_mode && w_line_dirty) begin
          w_wb_load = 1'b1;
          w_next    = ST_WB;
        end else begin
          w_line_done = 1'b1;
        end
      end
      ST_WB: begin
        w_line_done = wb_ack_i;
      end
      default: w_next = ST_IDLE;
    endcase

    // CHECK (clean line) and WB (ack) share the invalidate-and-advance step.
    if (w_line_done) begin
      tag_wr_o      = 1'b1;
      tag_wr_addr_o = r_index;
      tag_wr_data_o = '0;
      if (r_index == LAST_IDX) begin
        w_next     = ST_IDLE;
        w_walk_end = 1'b1;
      end else begin
        w_index_nxt = r_index + 8'd1;
        w_next      = ST_READ;
      end
    end
  end

  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = r_done;
  assign wb_req_o  = r_wb_req;
  assign wb_addr_o = r_wb_addr;

`ifdef DCACHE_FLUSH_STATS_EN
  logic [8:0] r_wb_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_count <= '0;
    end else if (w_start) begin
      r_wb_count <= '0;
    end else if (r_state == ST_WB && wb_ack_i) begin
      r_wb_count <= r_wb_count + 9'd1;
    end
  end

  assign wb_count_o = r_wb_count;
`endif

endmodule

// File: tb/tb_dcache_tag_flush.sv
module tb_dcache_tag_flush;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, invalidate_i;
  logic        busy_o, done_o;
  logic        upd_valid_i, upd_ready_o;
  logic [7:0]  upd_index_i;
  logic [18:0] upd_tag_i;
  logic        upd_dirty_i;
  logic [7:0]  tag_rd_addr_o;
  logic [20:0] tag_rd_data_i;
  logic        tag_wr_o;
  logic [7:0]  tag_wr_addr_o;
  logic [20:0] tag_wr_data_o;
  logic        wb_req_o;
  logic [31:0] wb_addr_o;
  logic        wb_ack_i;
`ifdef DCACHE_FLUSH_STATS_EN
  logic [8:0]  wb_count_o;
`endif

  dcache_tag_flush #(.NUM_LINES(256), .LINE_OFFSET_W(5)) dut (
    .clk(clk), .rst(rst),
    .flush_i(flush_i), .invalidate_i(invalidate_i),
    .busy_o(busy_o), .done_o(done_o),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_index_i(upd_index_i), .upd_tag_i(upd_tag_i), .upd_dirty_i(upd_dirty_i),
    .tag_rd_addr_o(tag_rd_addr_o), .tag_rd_data_i(tag_rd_data_i),
    .tag_wr_o(tag_wr_o), .tag_wr_addr_o(tag_wr_addr_o), .tag_wr_data_o(tag_wr_data_o),
    .wb_req_o(wb_req_o), .wb_addr_o(wb_addr_o), .wb_ack_i(wb_ack_i)
`ifdef DCACHE_FLUSH_STATS_EN
    , .wb_count_o(wb_count_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: write-first synchronous tag RAM.
  bit   [20:0] mem [256];
  logic [20:0] ram_q = '0;
  always @(posedge clk) begin
    if (tag_wr_o) mem[tag_wr_addr_o] <= tag_wr_data_o;
    ram_q <= (tag_wr_o && tag_wr_addr_o == tag_rd_addr_o) ? tag_wr_data_o : mem[tag_rd_addr_o];
  end
  assign tag_rd_data_i = ram_q;

  // Write-back responder: acks in the ack_delay-th cycle of each request.
  int unsigned ack_delay = 1;
  int unsigned ack_cnt   = 0;
  initial begin
    wb_ack_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_req_o && !rst) begin
        ack_cnt++;
        wb_ack_i = (ack_cnt == ack_delay);
      end else begin
        ack_cnt  = 0;
        wb_ack_i = 1'b0;
      end
    end
  end

  // Reference model state.
  bit   [20:0] shadow [256];
  logic [28:0] wq[$];     // expected writes {addr, data} in order
  logic [31:0] wbq[$];    // expected write-back addresses in order
  bit          walk_active = 1'b0;
  int          exp_start = 0, exp_done = 0;
  int          exp_wb_cycles = 0, wb_cycles = 0;
  int          done_cnt = 0, done_base = 0, last_done_cyc = 0;
  logic [31:0] held_addr = '0, last_wb_addr = '0;
  bit          prev_req = 1'b0;
  bit          exp_busy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      exp_busy = walk_active && (cyc > exp_start) && (cyc < exp_done);
      chk("busy", busy_o, exp_busy);
      chk("done", done_o, walk_active && cyc == exp_done);
      chk("upd_ready", upd_ready_o, !exp_busy && !flush_i && !invalidate_i);
      if (done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (tag_wr_o) begin
        if (wq.size() == 0) begin
          chk("spurious_wr", tag_wr_o, 1'b0);
        end else begin
          logic [28:0] e;
          e = wq.pop_front();
          chk("wr_addr", tag_wr_addr_o, e[28:21]);
          chk("wr_data", tag_wr_data_o, e[20:0]);
        end
      end
      if (wb_req_o) begin
        wb_cycles++;
        if (!prev_req) begin
          if (wbq.size() == 0) begin
            chk("spurious_wb", wb_req_o, 1'b0);
          end else begin
            logic [31:0] a;
            a = wbq.pop_front();
            chk("wb_addr", wb_addr_o, a);
          end
          held_addr    = wb_addr_o;
          last_wb_addr = wb_addr_o;
        end else begin
          chk("wb_addr_stable", wb_addr_o, held_addr);
        end
        chk("wb_ack_write", tag_wr_o, wb_ack_i);
      end
    end
    prev_req = wb_req_o;
  end

  task automatic do_update(input logic [7:0] idx, input logic [18:0] tag, input logic dirty);
    upd_valid_i = 1'b1;
    upd_index_i = idx;
    upd_tag_i   = tag;
    upd_dirty_i = dirty;
    shadow[idx] = {1'b1, dirty, tag};
    wq.push_back({idx, 1'b1, dirty, tag});
    @(posedge clk);
    #1;
    upd_valid_i = 1'b0;
  endtask

  // Pulses the start inputs; model expectations come from the shadow tags.
  task automatic start_walk(input bit fl, input bit inv, input bit upd, input int unsigned d);
    int ndirty;
    ndirty    = 0;
    ack_delay = d;
    for (int i = 0; i < 256; i++) begin
      if (fl && shadow[i][20] && shadow[i][19]) begin
        wbq.push_back({shadow[i][18:0], 8'(i), 5'b0});
        ndirty++;
      end
      wq.push_back({8'(i), 21'h0});
    end
    exp_start     = cyc;
    exp_done      = cyc + 513 + ndirty * int'(d);
    exp_wb_cycles = ndirty * int'(d);
    wb_cycles     = 0;
    done_base     = done_cnt;
    walk_active   = 1'b1;
    flush_i       = fl;
    invalidate_i  = inv;
    if (upd) begin
      upd_valid_i = 1'b1;
      upd_index_i = 8'h44;
      upd_tag_i   = 19'h55555;
      upd_dirty_i = 1'b1;
    end
    @(posedge clk);
    #1;
    flush_i      = 1'b0;
    invalidate_i = 1'b0;
    upd_valid_i  = 1'b0;
  endtask

  task automatic finish_walk(input string name);
    while (cyc <= exp_done + 2) @(posedge clk);
    #1;
    chk({name, "_wq_empty"}, wq.size(), 0);
    chk({name, "_wbq_empty"}, wbq.size(), 0);
    chk({name, "_wb_cycles"}, wb_cycles, exp_wb_cycles);
    chk({name, "_done_once"}, done_cnt - done_base, 1);
    chk({name, "_done_cycle"}, last_done_cyc, exp_done);
    walk_active = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0; invalidate_i = 1'b0;
    upd_valid_i = 1'b0; upd_index_i = '0; upd_tag_i = '0; upd_dirty_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_wr", tag_wr_o, 1'b0);
    chk("rst_wb_req", wb_req_o, 1'b0);
    chk("rst_wb_addr", wb_addr_o, 32'h0);
    chk("rst_rd_addr", tag_rd_addr_o, 8'h0);
    chk("rst_wr_addr", tag_wr_addr_o, 8'h0);
    chk("rst_wr_data", tag_wr_data_o, 21'h0);
`ifdef DCACHE_FLUSH_STATS_EN
    chk("rst_wb_count", wb_count_o, 9'd0);
`endif

    // Single update, literal expectations.
    @(posedge clk);
    #1;
    upd_valid_i = 1'b1; upd_index_i = 8'h3A; upd_tag_i = 19'h12345; upd_dirty_i = 1'b1;
    shadow[8'h3A] = 21'h192345;
    wq.push_back({8'h3A, 21'h192345});
    @(negedge clk);
    chk("upd_lit_ready", upd_ready_o, 1'b1);
    chk("upd_lit_wr", tag_wr_o, 1'b1);
    chk("upd_lit_addr", tag_wr_addr_o, 8'h3A);
    chk("upd_lit_data", tag_wr_data_o, 21'h192345);
    @(posedge clk);
    #1;
    upd_valid_i = 1'b0;

    // Fill every line valid and dirty, then invalidate-only walk.
    for (int i = 0; i < 256; i++) do_update(8'(i), 19'(i * 613 + 1), 1'b1);
    start_walk(1'b0, 1'b1, 1'b0, 1);
    finish_walk("inv_all");
    chk("inv_all_513", last_done_cyc - exp_start, 513);
    chk("inv_all_no_wb", wb_cycles, 0);

    // Flush with only line 5 dirty, ack after 4 cycles.
    do_update(8'd5, 19'h00001, 1'b1);
    do_update(8'd7, 19'h00002, 1'b0);
    start_walk(1'b1, 1'b0, 1'b0, 4);
    finish_walk("flush_one");
    chk("flush_one_addr_lit", last_wb_addr, 32'h000020A0);
    chk("flush_one_req_cycles", wb_cycles, 4);
    chk("flush_one_done_lit", last_done_cyc - exp_start, 517);

    // Flush + invalidate + update together: flush mode, update refused.
    do_update(8'd10, 19'h0000A, 1'b1);
    do_update(8'd200, 19'h3C3C3, 1'b1);
    do_update(8'd7, 19'h00003, 1'b0);
    do_update(8'd255, 19'h7FFFF, 1'b1);
    start_walk(1'b1, 1'b1, 1'b1, 1);
    finish_walk("flush_both");
    chk("flush_both_last_addr", last_wb_addr, 32'hFFFFFFE0);
    chk("flush_both_req_cycles", wb_cycles, 3);
`ifdef DCACHE_FLUSH_STATS_EN
    chk("stats_after_flush", wb_count_o, 9'd3);
`endif
    start_walk(1'b0, 1'b1, 1'b0, 1);
    finish_walk("inv_clean");
`ifdef DCACHE_FLUSH_STATS_EN
    chk("stats_after_inv", wb_count_o, 9'd0);
`endif

    // Reset while waiting for a write-back ack at index 100.
    do_update(8'd100, 19'h0ABCD, 1'b1);
    do_update(8'd150, 19'h00077, 1'b1);
    start_walk(1'b1, 1'b0, 1'b0, 1000);
    for (int k = 0; k < 600; k++) begin
      if (wb_req_o) break;
      @(negedge clk);
    end
    chk("rstwb_req_seen", wb_req_o, 1'b1);
    chk("rstwb_addr_lit", wb_addr_o, 32'h1579AC80);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wq.delete();
    wbq.delete();
    walk_active = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) shadow[i] = '0;
    @(negedge clk);
    chk("rstwb_busy", busy_o, 1'b0);
    chk("rstwb_req", wb_req_o, 1'b0);
    chk("rstwb_wr", tag_wr_o, 1'b0);
    @(posedge clk);
    #1;
    start_walk(1'b1, 1'b0, 1'b0, 2);
    finish_walk("restart");
    chk("restart_last_addr", last_wb_addr, {19'h00077, 8'd150, 5'b0});
    chk("restart_done_lit", last_done_cyc - exp_start, 517);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
